// File: rtl/instr_fetch_rom.sv
// Loadable instruction store with a built-in program counter and a
// valid/ready fetch handshake. The program is written through the load port
// while idle or halted; start streams it out from address 0, honouring jumps,
// halting at the end of the program and flagging jumps past its end.
module instr_fetch_rom #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              valid,
    output logic              busy,
    output logic              fault
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [LEN_W-1:0]   prog_len;

    logic               load_ok_c;
    logic               start_ok_c;
    logic               accept_c;
    logic [LEN_W-1:0]   target_c;
    logic               target_in_c;

    // Qualify load/start/handshake and compute the next fetch address without wrap.
    always_comb begin
        load_ok_c   = 1'b0;
        start_ok_c  = 1'b0;
        accept_c    = 1'b0;
        target_c    = '0;
        target_in_c = 1'b0;

        load_ok_c   = load_en && (state != RUN);
        start_ok_c  = start && !load_en && (state != RUN) && (prog_len != '0);
        accept_c    = (state == RUN) && valid && ready;
        target_c    = jump ? {1'b0, jump_addr} : ({1'b0, pc} + LEN_W'(1));
        target_in_c = (target_c < prog_len);
    end

    // Program memory: cleared on reset, writable only outside RUN.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (load_ok_c) begin
            mem[load_addr] <= load_data;
        end
    end

    // Program length grows to cover the highest address written so far.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            prog_len <= '0;
        end else if (load_ok_c && ({1'b0, load_addr} >= prog_len)) begin
            prog_len <= {1'b0, load_addr} + LEN_W'(1);
        end
    end

    // Fetch sequencer: IDLE/HALT accept start, RUN issues one word per handshake.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            instruction <= '0;
            pc          <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start_ok_c) begin
                        state       <= RUN;
                        pc          <= '0;
                        instruction <= mem[0];
                        valid       <= 1'b1;
                        busy        <= 1'b1;
                        fault       <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        if (target_in_c) begin
                            pc          <= target_c[ADDR_W-1:0];
                            instruction <= mem[target_c[ADDR_W-1:0]];
                        end else begin
                            state <= HALT;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            if (jump) begin
                                fault <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_rom.sv
// Bench for instr_fetch_rom: directed scenarios plus a randomized phase, all
// checked every cycle against a program-level reference model.
module tb_instr_fetch_rom;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int DEPTH = 32;

    logic              clk;
    logic              clear;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic              ready;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] pc;
    logic              valid;
    logic              busy;
    logic              fault;

    int errors;
    int checks;

    // Reference model state
    int m_mem [DEPTH];
    int m_len;
    int m_run;
    int m_pc;
    int m_instr;
    int m_fault;

    int prog5 [5];
    int got [$];

    instr_fetch_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .clear(clear), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .ready(ready), .jump(jump),
        .jump_addr(jump_addr), .instruction(instruction), .pc(pc),
        .valid(valid), .busy(busy), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_len = 0; m_run = 0; m_pc = 0; m_instr = 0; m_fault = 0;
    endtask

    // Program-level behaviour for one clock edge, from the current inputs.
    task automatic model_edge();
        int t;
        if (m_run == 0) begin
            if (load_en) begin
                m_mem[int'(load_addr)] = int'(load_data);
                if (int'(load_addr) >= m_len) m_len = int'(load_addr) + 1;
            end else if (start && m_len > 0) begin
                m_run = 1; m_pc = 0; m_instr = m_mem[0]; m_fault = 0;
            end
        end else if (ready) begin
            t = jump ? int'(jump_addr) : m_pc + 1;
            if (t < m_len) begin
                m_pc = t; m_instr = m_mem[t];
            end else begin
                m_run = 0;
                if (jump) m_fault = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check("instruction", 32'(instruction), 32'(m_instr));
        check("pc", 32'(pc), 32'(m_pc));
        check("valid", 32'(valid), 32'(m_run));
        check("busy", 32'(busy), 32'(m_run));
        check("fault", 32'(fault), 32'(m_fault));
    endtask

    // One clock: record any accepted word, advance the model, compare after the edge.
    task automatic step();
        if (valid && ready) got.push_back(int'(instruction));
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic quiet();
        load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; ready = 1'b0; jump = 1'b0; jump_addr = '0;
    endtask

    task automatic do_clear();
        #2 clear = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #2 clear = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input int d);
        quiet();
        load_en = 1'b1; load_addr = ADDR_W'(a); load_data = DATA_W'(d);
        step();
        load_en = 1'b0;
    endtask

    task automatic load_prog5();
        for (int i = 0; i < 5; i++) load_word(i, prog5[i]);
    endtask

    task automatic do_start();
        quiet();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_halt(input int max_cycles);
        quiet();
        ready = 1'b1;
        for (int i = 0; i < max_cycles && m_run != 0; i++) step();
        check("halt_timeout", 32'(busy), 32'd0);
        ready = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        prog5[0] = 'h44; prog5[1] = 'h49; prog5[2] = 'h18; prog5[3] = 'h89; prog5[4] = 'hC3;
        quiet();
        clear = 1'b1;
        model_reset();
        #1;
        check_outputs();
        #12 clear = 1'b0;
        @(posedge clk);
        #1;

        // Straight run with ready held high
        load_prog5();
        do_start();
        check("first_instr", 32'(instruction), 32'h44);
        got.delete();
        run_until_halt(20);
        check("seq_len", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("seq_word", 32'(got[i]), 32'(prog5[i]));
        check("end_pc", 32'(pc), 32'd4);
        check("end_fault", 32'(fault), 32'd0);

        // Replay with ready stalling 1,0,0,1,...
        do_start();
        got.delete();
        for (int i = 0; i < 40 && m_run != 0; i++) begin
            quiet();
            ready = ((i % 3) == 0);
            step();
        end
        check("stall_halt", 32'(busy), 32'd0);
        check("stall_len", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("stall_word", 32'(got[i]), 32'(prog5[i]));

        // Jumps: back to 1, self-loop at 3, then out of range -> fault
        do_start();
        begin
            int n3;
            n3 = 0;
            for (int i = 0; i < 30 && m_run != 0; i++) begin
                quiet();
                ready = 1'b1;
                if (m_pc == 3) begin
                    jump = 1'b1;
                    jump_addr = (n3 == 0) ? 5'd1 : (n3 == 1) ? 5'd3 : 5'd7;
                    n3++;
                end
                step();
                if (n3 == 1 && m_pc == 1 && jump) check("jump_back", 32'(instruction), 32'h49);
            end
        end
        check("jump_fault", 32'(fault), 32'd1);
        check("jump_valid", 32'(valid), 32'd0);

        // Single word at the top address: prog_len spans the whole store
        do_clear();
        load_word(31, 'hA5);
        do_start();
        check("top_start_pc", 32'(pc), 32'd0);
        for (int k = 0; k < 3; k++) begin
            quiet();
            ready = 1'b1; jump = 1'b1; jump_addr = 5'd31;
            step();
        end
        check("top_instr", 32'(instruction), 32'hA5);
        quiet();
        ready = 1'b1;
        step();
        check("top_halt_pc", 32'(pc), 32'd31);
        check("top_halt_busy", 32'(busy), 32'd0);
        check("top_fault", 32'(fault), 32'd0);

        // Load attempt during RUN is dropped
        do_clear();
        load_prog5();
        do_start();
        quiet();
        load_en = 1'b1; load_addr = 5'd2; load_data = 8'hFF;
        step();
        run_until_halt(20);
        do_start();
        quiet();
        ready = 1'b1;
        step();
        step();
        check("replay_pc2", 32'(pc), 32'd2);
        check("replay_word2", 32'(instruction), 32'h18);

        // Asynchronous clear while valid, then start with an empty program
        quiet();
        do_clear();
        check("clr_valid", 32'(valid), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("empty_start_busy", 32'(busy), 32'd0);

        // Randomized traffic: random program, random start/load/ready/jump
        begin
            int len;
            len = 1 + int'($urandom_range(0, 31));
            for (int a = 0; a < len; a++) load_word(a, int'($urandom_range(0, 255)));
            // start together with a load: load wins
            quiet();
            start = 1'b1; load_en = 1'b1; load_addr = 5'd0; load_data = 8'h3C;
            step();
            for (int c = 0; c < 600; c++) begin
                quiet();
                start     = ($urandom_range(0, 5) == 0);
                load_en   = ($urandom_range(0, 15) == 0);
                load_addr = ADDR_W'($urandom_range(0, 31));
                load_data = DATA_W'($urandom_range(0, 255));
                ready     = ($urandom_range(0, 2) != 0);
                jump      = ($urandom_range(0, 4) == 0);
                jump_addr = ADDR_W'($urandom_range(0, 31));
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
